// File: rtl/sbm_mult_pipe.sv
// Fully pipelined WIDTHxWIDTH multiplier, signed or unsigned per operation.
// An operand register feeds a registered pairwise adder tree; a full-pipeline stall provides backpressure.
module sbm_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               mode_signed,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p_out,
    output logic [TAG_W-1:0]   tag_out
);
    localparam int LVLS = $clog2(WIDTH);
    localparam int PW   = 2 * WIDTH;

    logic             stall;
    logic [LVLS:0]    vld_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [TAG_W-1:0] tag_q  [LVLS+1];
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    pp     [WIDTH];
    logic [PW-1:0]    node_d [1:WIDTH-1];
    logic [PW-1:0]    node_q [1:WIDTH-1];

    assign stall     = vld_q[LVLS] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_q[LVLS];
    assign p_out     = node_q[1];
    assign tag_out   = tag_q[LVLS];

    // Signed mode: rows are sign-extended and the multiplier-MSB row carries weight -2^(W-1).
    always_comb begin
        a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pp[i] = b_q[i] ? (a_ext << i) : '0;
        end
        if (sgn_q) begin
            pp[WIDTH-1] = -pp[WIDTH-1];
        end
    end

    // Heap-ordered tree: node k sums children 2k and 2k+1; indices >= WIDTH are the rows.
    always_comb begin
        for (int unsigned k = WIDTH / 2; k < WIDTH; k++) begin
            node_d[k] = pp[2*k - WIDTH] + pp[2*k + 1 - WIDTH];
        end
        for (int unsigned k = 1; k < WIDTH / 2; k++) begin
            node_d[k] = node_q[2*k] + node_q[2*k + 1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            for (int unsigned l = 0; l <= LVLS; l++) begin
                tag_q[l] <= '0;
            end
            for (int unsigned k = 1; k < WIDTH; k++) begin
                node_q[k] <= '0;
            end
        end else if (!stall) begin
            vld_q    <= {vld_q[LVLS-1:0], in_valid};
            a_q      <= a_in;
            b_q      <= b_in;
            sgn_q    <= mode_signed;
            tag_q[0] <= tag_in;
            for (int unsigned l = 1; l <= LVLS; l++) begin
                tag_q[l] <= tag_q[l-1];
            end
            for (int unsigned k = 1; k < WIDTH; k++) begin
                node_q[k] <= node_d[k];
            end
        end
    end
endmodule

// File: tb/tb_sbm_mult_pipe.sv
// Bench for sbm_mult_pipe (WIDTH=8, TAG_W=4): vector table, random streams and
// handshake/reset corner cases, checked against a queue-based scoreboard.
`timescale 1ns/1ps
module tb_sbm_mult_pipe;
    localparam int WIDTH = 8;
    localparam int TAG_W = 4;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sg;
        logic [3:0]  tag;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic        mode_signed = 1'b0;
    logic [3:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] p_out;
    logic [3:0]  tag_out;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   rnd_ready = 1'b0;
    vec_t vt[10];

    sbm_mult_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .mode_signed(mode_signed),
        .tag_in     (tag_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p_out      (p_out),
        .tag_out    (tag_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sg);
        int sa;
        int sbv;
        if (sg) begin
            sa  = int'($signed(a));
            sbv = int'($signed(b));
        end else begin
            sa  = int'(a);
            sbv = int'(b);
        end
        return 16'(sa * sbv);
    endfunction

    // Holds the operation until it is accepted; the expectation is queued in the accepting cycle.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sg,
                        input logic [3:0] t, input logic [15:0] e);
        int n = 0;
        a_in = a; b_in = b; mode_signed = sg; tag_in = t; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back('{e, t});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        idle(2);
    endtask

    // Called just after the accept edge: cycle n is the one following edge accept+n-1.
    task automatic expect_latency(input string name);
        int n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, n, 4);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got p=0x%0h tag=0x%0h, required no result", p_out, tag_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("p_out", p_out, mon_e.p);
                check("tag_out", tag_out, mon_e.tag);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'hFF, 8'hFF, 1'b0, 4'h3, 16'hFE01};
        vt[1] = '{8'h80, 8'h80, 1'b1, 4'h1, 16'h4000};
        vt[2] = '{8'hFF, 8'h7F, 1'b1, 4'h2, 16'hFF81};
        vt[3] = '{8'hFF, 8'h7F, 1'b0, 4'h4, 16'h7E81};
        vt[4] = '{8'h00, 8'hFF, 1'b1, 4'h5, 16'h0000};
        vt[5] = '{8'h7F, 8'h7F, 1'b1, 4'h6, 16'h3F01};
        vt[6] = '{8'h80, 8'h7F, 1'b1, 4'h7, 16'hC080};
        vt[7] = '{8'h80, 8'hFF, 1'b1, 4'h8, 16'h0080};
        vt[8] = '{8'h80, 8'h80, 1'b0, 4'h9, 16'h4000};
        vt[9] = '{8'h01, 8'h80, 1'b1, 4'hA, 16'hFF80};

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_p_out", p_out, 0);
        check("rst_tag_out", tag_out, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        idle(1);

        // Single operation into an empty pipeline: value, tag and latency.
        send(8'hFF, 8'hFF, 1'b0, 4'h3, 16'hFE01);
        expect_latency("t1_latency");
        idle(3);

        for (int i = 0; i < 10; i++) begin
            send(vt[i].a, vt[i].b, vt[i].sg, vt[i].tag, vt[i].p);
        end
        drain();

        // Back-to-back random stream: results must emerge as one unbroken run of 16.
        fork
            begin : t3_send
                logic [7:0] ra;
                logic [7:0] rb;
                logic       rs;
                logic [3:0] rt;
                for (int i = 0; i < 16; i++) begin
                    ra = 8'($urandom); rb = 8'($urandom);
                    rs = 1'($urandom_range(0, 1)); rt = 4'(i);
                    send(ra, rb, rs, rt, model(ra, rb, rs));
                end
            end
            begin : t3_run
                int n = 0;
                int r = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                while (out_valid && r < 40) begin
                    r++;
                    @(negedge clk);
                end
                check("t3_run_length", r, 16);
            end
        join
        drain();

        // Five-cycle output stall during a stream.
        fork
            begin : t4_send
                logic [7:0] ra;
                logic [7:0] rb;
                logic       rs;
                for (int i = 0; i < 14; i++) begin
                    ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, 4'(i + 2), model(ra, rb, rs));
                end
            end
            begin : t4_stall
                int n = 0;
                logic [15:0] hp;
                logic [3:0]  ht;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                hp = p_out;
                ht = tag_out;
                check("t4_stall_valid", out_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    check("t4_in_ready_low", in_ready, 0);
                    if (i > 0) begin
                        check("t4_p_hold", p_out, hp);
                        check("t4_tag_hold", tag_out, ht);
                    end
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight, the oldest parked at the output.
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 4'hB, 16'h0242);
        send(8'h33, 8'h44, 1'b1, 4'hC, model(8'h33, 8'h44, 1'b1));
        send(8'h55, 8'h66, 1'b0, 4'hD, model(8'h55, 8'h66, 1'b0));
        begin : t5_wait
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t5_pre_valid", out_valid, 1);
        end
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_valid_drop", out_valid, 0);
        check("t5_p_cleared", p_out, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        idle(8);
        @(negedge clk);
        check("t5_no_ghost", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        idle(1);
        send(8'd2, 8'd3, 1'b0, 4'h5, 16'd6);
        expect_latency("t5_latency");
        drain();

        // Sparse input with random backpressure.
        rnd_ready = 1'b1;
        begin : t6_send
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rs;
            for (int i = 0; i < 12; i++) begin
                ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
                send(ra, rb, rs, 4'(15 - i), model(ra, rb, rs));
                idle(2);
            end
        end
        rnd_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        idle(4);
        @(negedge clk);
        check("final_idle", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
